// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  localparam logic [3:0] ANODE_OFF = 4'hF;

  typedef enum logic {
    PH_ON  = 1'b0,
    PH_OFF = 1'b1
  } blink_phase_e;

endpackage

// File: rtl/bcd_to_7seg.sv
// BCD nibble to active-low segment pattern.
// Nibbles A..F are not valid BCD and show blank.
module bcd_to_7seg
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_BLANK;
    case (bcd)
      4'd0:    seg_n = SEG_0;
      4'd1:    seg_n = SEG_1;
      4'd2:    seg_n = SEG_2;
      4'd3:    seg_n = SEG_3;
      4'd4:    seg_n = SEG_4;
      4'd5:    seg_n = SEG_5;
      4'd6:    seg_n = SEG_6;
      4'd7:    seg_n = SEG_7;
      4'd8:    seg_n = SEG_8;
      4'd9:    seg_n = SEG_9;
      default: seg_n = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// 4-digit multiplexed common-anode display driver with
// dead time, fixed dp, leading-zero blanking and blink.
module seven_seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV     = 50_000,
  parameter int DEAD_CYCLES  = 500,
  parameter int BLINK_FRAMES = 64,
  parameter int DP_DIGIT     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] segments,
  input  logic        lz_blank,
  input  logic        blink_en,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [3:0]  an_n,
  output logic        frame_tick
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [PW:0]   DEAD      = (PW+1)'(DEAD_CYCLES);
  localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);
  localparam logic [1:0]    DP_IDX    = 2'(DP_DIGIT);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  blink_phase_e  phase_q, phase_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;
  logic          ft_q, ft_d;

  logic       slot_wrap;
  logic       frame_wrap;
  logic [3:0] nib;
  logic [6:0] pat;
  logic       dead;
  logic       blink_off;
  logic       lz_hit;

  assign nib = shadow_q[{idx_q, 2'b00} +: 4];

  bcd_to_7seg u_dec (
    .bcd   (nib),
    .seg_n (pat)
  );

  always_comb begin
    slot_wrap  = (presc_q == PRESC_MAX);
    frame_wrap = slot_wrap && (idx_q == 2'd0);
    dead       = ({1'b0, presc_q} < DEAD);
    blink_off  = blink_en && (phase_q == PH_OFF);
    lz_hit     = lz_blank && (idx_q == 2'd3) && (nib == 4'd0);

    presc_d  = slot_wrap ? '0 : presc_q + 1'b1;
    idx_d    = slot_wrap ? idx_q - 2'd1 : idx_q;
    shadow_d = frame_wrap ? segments : shadow_q;
    ft_d     = frame_wrap;

    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (frame_wrap) begin
      if (fcnt_q == FRAME_MAX) begin
        fcnt_d  = '0;
        phase_d = (phase_q == PH_ON) ? PH_OFF : PH_ON;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end

    an_d  = ANODE_OFF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (!dead && !blink_off) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = lz_hit ? SEG_BLANK : pat;
      dp_d  = ~(idx_q == DP_IDX);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q  <= '0;
      idx_q    <= 2'd3;
      shadow_q <= 16'h0000;
      fcnt_q   <= '0;
      phase_q  <= PH_ON;
      seg_q    <= SEG_BLANK;
      dp_q     <= 1'b1;
      an_q     <= ANODE_OFF;
      ft_q     <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      fcnt_q   <= fcnt_d;
      phase_q  <= phase_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      an_q     <= an_d;
      ft_q     <= ft_d;
    end
  end

  assign seg_n      = seg_q;
  assign dp_n       = dp_q;
  assign an_n       = an_q;
  assign frame_tick = ft_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver with a
// 4-cycle slot, 1-cycle dead time and 2-frame blink.
module tb_seven_seg_scan_driver;

  logic        clk;
  logic        reset;
  logic [15:0] segments;
  logic        lz_blank;
  logic        blink_en;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_tick;

  int total;
  int bad;
  int c;

  seven_seg_scan_driver #(
    .SCAN_DIV     (4),
    .DEAD_CYCLES  (1),
    .BLINK_FRAMES (2),
    .DP_DIGIT     (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .segments   (segments),
    .lz_blank   (lz_blank),
    .blink_en   (blink_en),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
    c += n;
  endtask

  task automatic goto(input int target);
    if (target > c) step(target - c);
  endtask

  task automatic chk_an(input string tag, input logic [3:0] e);
    total++;
    assert (an_n === e) else begin
      bad++;
      $error("FAIL %s c=%0d an_n got=%h exp=%h", tag, c, an_n, e);
    end
  endtask

  task automatic chk_lit(input string tag, input logic [3:0] an_e,
                         input logic [6:0] seg_e, input logic dp_e);
    chk_an(tag, an_e);
    total++;
    assert (seg_n === seg_e) else begin
      bad++;
      $error("FAIL %s c=%0d seg_n got=%h exp=%h", tag, c, seg_n, seg_e);
    end
    total++;
    assert (dp_n === dp_e) else begin
      bad++;
      $error("FAIL %s c=%0d dp_n got=%b exp=%b", tag, c, dp_n, dp_e);
    end
  endtask

  task automatic chk_ft(input string tag, input logic e);
    total++;
    assert (frame_tick === e) else begin
      bad++;
      $error("FAIL %s c=%0d frame_tick got=%b exp=%b", tag, c, frame_tick, e);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    c        = 0;
    reset    = 1'b1;
    segments = 16'h0000;
    lz_blank = 1'b0;
    blink_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    c = 0;

    // reset state and first lit digit
    step(2);
    chk_lit("boot_d3", 4'h7, 7'h40, 1'b1);
    chk_ft("boot_ft", 1'b0);

    // asynchronous reset mid-slot blanks immediately
    reset = 1'b1;
    #2;
    chk_lit("async_rst", 4'hF, 7'h7F, 1'b1);
    chk_ft("async_rst_ft", 1'b0);
    segments = 16'h1234;
    @(negedge clk);
    reset = 1'b0;
    c = 0;

    step(1);
    chk_lit("rel_dead", 4'hF, 7'h7F, 1'b1);
    step(1);
    chk_lit("rel_d3_sh0", 4'h7, 7'h40, 1'b1);
    goto(5);
    chk_an("rel_dead2", 4'hF);
    goto(6);
    chk_lit("rel_d2_sh0", 4'hB, 7'h40, 1'b0);
    goto(15);
    chk_ft("pre_tick", 1'b0);
    goto(16);
    chk_ft("tick1", 1'b1);
    chk_lit("tick1_old", 4'hE, 7'h40, 1'b1);

    // 1234 across one frame, with tick period check
    for (int i = 17; i <= 32; i++) begin
      step(1);
      chk_ft("tick_period", (c == 32));
      if (c == 17) chk_lit("s3_dead", 4'hF, 7'h7F, 1'b1);
      if (c == 18) chk_lit("s3_1", 4'h7, 7'h79, 1'b1);
      if (c == 21) chk_an("s2_dead", 4'hF);
      if (c == 22) chk_lit("s2_2", 4'hB, 7'h24, 1'b0);
      if (c == 25) chk_an("s1_dead", 4'hF);
      if (c == 26) chk_lit("s1_3", 4'hD, 7'h30, 1'b1);
      if (c == 29) chk_an("s0_dead", 4'hF);
      if (c == 30) chk_lit("s0_4", 4'hE, 7'h19, 1'b1);
    end

    // mid-frame change waits for the next reload
    goto(34);
    chk_lit("tear_d3", 4'h7, 7'h79, 1'b1);
    segments = 16'h5678;
    goto(38);
    chk_lit("tear_d2", 4'hB, 7'h24, 1'b0);
    goto(42);
    chk_lit("tear_d1", 4'hD, 7'h30, 1'b1);
    goto(46);
    chk_lit("tear_d0", 4'hE, 7'h19, 1'b1);
    goto(48);
    chk_ft("tick3", 1'b1);
    goto(50);
    chk_lit("new_d3", 4'h7, 7'h12, 1'b1);
    goto(54);
    chk_lit("new_d2", 4'hB, 7'h02, 1'b0);
    goto(58);
    chk_lit("new_d1", 4'hD, 7'h78, 1'b1);
    goto(62);
    chk_lit("new_d0", 4'hE, 7'h00, 1'b1);

    // leading-zero blank and invalid BCD
    segments = 16'h0A09;
    lz_blank = 1'b1;
    goto(66);
    chk_lit("lz_d3", 4'h7, 7'h7F, 1'b1);
    goto(70);
    chk_lit("inv_d2", 4'hB, 7'h7F, 1'b0);
    goto(74);
    chk_lit("lz_d1", 4'hD, 7'h40, 1'b1);
    goto(78);
    chk_lit("lz_d0", 4'hE, 7'h10, 1'b1);
    lz_blank = 1'b0;
    goto(82);
    chk_lit("nolz_d3", 4'h7, 7'h40, 1'b1);

    // blink: phase already running since reset
    blink_en = 1'b1;
    goto(86);
    chk_lit("blink_on", 4'hB, 7'h7F, 1'b0);
    goto(98);
    chk_an("blink_off_a", 4'hF);
    total++;
    assert (dp_n === 1'b1) else begin
      bad++;
      $error("FAIL blink_off_dp c=%0d dp_n got=%b exp=1", c, dp_n);
    end
    goto(126);
    chk_an("blink_off_b", 4'hF);
    goto(130);
    chk_lit("blink_on2_d3", 4'h7, 7'h40, 1'b1);
    goto(158);
    chk_lit("blink_on2_d0", 4'hE, 7'h10, 1'b1);
    goto(162);
    chk_an("blink_off2", 4'hF);
    blink_en = 1'b0;
    goto(170);
    chk_lit("blink_dis", 4'hD, 7'h40, 1'b1);
    blink_en = 1'b1;
    goto(174);
    chk_an("blink_reen", 4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
